// File: rtl/operand_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : operand_loader                                                |
// | Purpose  : Collects two W-bit operands (A then B) serially over one      |
// |            valid/ready input bus and holds them with a select bit. It     |
// |            presents them as a stable (i1, i2, sel) triple behind an      |
// |            output valid/ready handshake. It also counts how many pairs   |
// |            the consumer has taken.                                       |
// | Ports    : clk, rst_b (async, active low), abort (sync discard)          |
// |            in_valid/in_ready/in_data/in_sel   - serial operand input     |
// |            out_valid/out_ready                - pair handshake           |
// |            out_i1/out_i2/out_sel              - held operand triple      |
// |            xfer_cnt                           - consumed pairs mod 2^N   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module operand_loader #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_i1,
  output logic [W-1:0]     out_i2,
  output logic             out_sel,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     i1_q, i1_d;
  logic [W-1:0]     i2_q, i2_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Abort outranks every handshake in its cycle: nothing is captured or counted.
  always_comb begin
    state_d = state_q;
    i1_d    = i1_q;
    i2_d    = i2_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = WAIT_A;
      i1_d    = '0;
      i2_d    = '0;
      sel_d   = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_A: begin
          if (in_valid) begin
            i1_d    = in_data;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (in_valid) begin
            i2_d    = in_data;
            sel_d   = in_sel;
            state_d = HOLD;
          end
        end
        HOLD: begin
          // The operand registers keep their values after consumption; only
          // out_valid qualifies them for the consumer.
          if (out_ready) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = WAIT_A;
          end
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= WAIT_A;
      i1_q    <= '0;
      i2_q    <= '0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags come from state alone, so the inputs have no
  // combinational path to any output.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_i1    = i1_q;
  assign out_i2    = i2_q;
  assign out_sel   = sel_q;
  assign xfer_cnt  = cnt_q;

endmodule
`default_nettype wire
